// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller for the M stage: prioritises causes, captures the CP0
// update values and sequences the pipeline flush and PC redirect handshake.
module exc_commit_ctrl #(
  parameter int unsigned NUM_HW_INT   = 6,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_m,
  input  logic                  stall_m,
  input  logic [31:0]           pc_m,
  input  logic                  in_ds_m,
  input  logic [7:0]            except_m,
  input  logic                  adel_m,
  input  logic                  ades_m,
  input  logic [31:0]           bad_addr_m,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  input  logic                  redirect_ready,
  output logic [NUM_HW_INT-1:0] ip_sync,
  output logic                  flush,
  output logic                  cp0_we,
  output logic [31:0]           excepttype,
  output logic [31:0]           epc_out,
  output logic [31:0]           badvaddr_out,
  output logic                  badv_we,
  output logic                  bd_out,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRedirect
  } state_e;

  localparam logic [2:0] LastCnt = 3'(FLUSH_CYCLES - 1);

  localparam logic [4:0] CodeInt  = 5'h01;
  localparam logic [4:0] CodeAdel = 5'h04;
  localparam logic [4:0] CodeAdes = 5'h05;
  localparam logic [4:0] CodeSys  = 5'h08;
  localparam logic [4:0] CodeBp   = 5'h09;
  localparam logic [4:0] CodeRi   = 5'h0a;
  localparam logic [4:0] CodeOv   = 5'h0c;
  localparam logic [4:0] CodeEret = 5'h0e;

  state_e                state;
  logic [2:0]            flush_cnt;
  logic [NUM_HW_INT-1:0] ip_meta;

  logic                  int_pending;
  logic                  exc_hit;
  logic [4:0]            exc_code;
  logic                  is_eret;
  logic                  addr_err;
  logic [31:0]           badv_val;
  logic [31:0]           epc_val;
  logic                  commit;

  logic                  unused_bits;
  assign unused_bits = ^{cp0_cause[31:10], cp0_cause[7:0], except_m[1:0],
                         cp0_status[31:NUM_HW_INT+10], cp0_status[7:2]};

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ip_meta <= '0;
      ip_sync <= '0;
    end else begin
      ip_meta <= hw_int;
      ip_sync <= ip_meta;
    end
  end

  assign int_pending = (({ip_sync, cp0_cause[9:8]} & cp0_status[NUM_HW_INT+9:8]) != '0) &&
                       !cp0_status[1] && cp0_status[0];

  // Fixed priority, highest first.
  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 5'h00;
    is_eret  = 1'b0;
    addr_err = 1'b0;
    badv_val = 32'h0;
    if (int_pending) begin
      exc_code = CodeInt;
    end else if (except_m[7]) begin
      exc_code = CodeAdel;
      addr_err = 1'b1;
      badv_val = pc_m;
    end else if (adel_m) begin
      exc_code = CodeAdel;
      addr_err = 1'b1;
      badv_val = bad_addr_m;
    end else if (ades_m) begin
      exc_code = CodeAdes;
      addr_err = 1'b1;
      badv_val = bad_addr_m;
    end else if (except_m[6]) begin
      exc_code = CodeSys;
    end else if (except_m[5]) begin
      exc_code = CodeBp;
    end else if (except_m[4]) begin
      exc_code = CodeEret;
      is_eret  = 1'b1;
    end else if (except_m[3]) begin
      exc_code = CodeRi;
    end else if (except_m[2]) begin
      exc_code = CodeOv;
    end else begin
      exc_hit = 1'b0;
    end
  end

  assign epc_val = in_ds_m ? (pc_m - 32'd4) : pc_m;
  assign commit  = (state == StIdle) && valid_m && !stall_m && exc_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= StIdle;
      flush_cnt      <= 3'd0;
      flush          <= 1'b0;
      cp0_we         <= 1'b0;
      excepttype     <= 32'h0;
      epc_out        <= 32'h0;
      badvaddr_out   <= 32'h0;
      badv_we        <= 1'b0;
      bd_out         <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      case (state)
        StIdle: begin
          if (commit) begin
            state        <= StFlush;
            flush_cnt    <= 3'd0;
            flush        <= 1'b1;
            cp0_we       <= 1'b1;
            excepttype   <= {27'h0, exc_code};
            // eret leaves EPC unchanged, so present its current value.
            epc_out      <= is_eret ? cp0_epc : epc_val;
            badvaddr_out <= badv_val;
            badv_we      <= addr_err;
            bd_out       <= in_ds_m;
            redirect_pc  <= is_eret ? cp0_epc : EXC_VECTOR;
          end
        end
        StFlush: begin
          cp0_we <= 1'b0;
          if (flush_cnt == LastCnt) begin
            state          <= StRedirect;
            redirect_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end
        StRedirect: begin
          if (redirect_ready) begin
            state          <= StIdle;
            flush          <= 1'b0;
            excepttype     <= 32'h0;
            epc_out        <= 32'h0;
            badvaddr_out   <= 32'h0;
            badv_we        <= 1'b0;
            bd_out         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomised scoreboard bench for exc_commit_ctrl: stimulus pushes expected commits, a monitor
// pops them on cp0_we and follows each flush/redirect sequence to completion.
module tb_exc_commit_ctrl;

  localparam int unsigned FlushCycles = 2;
  localparam logic [31:0] ExcVec      = 32'hBFC0_0380;

  typedef struct {
    logic        valid;
    logic [31:0] code;
    logic [31:0] epc;
    logic [31:0] badv;
    logic [31:0] rpc;
    logic        badv_we;
    logic        bd;
    logic        chk_epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_m, stall_m, in_ds_m, adel_m, ades_m, redirect_ready;
  logic [31:0] pc_m, bad_addr_m, cp0_status, cp0_cause, cp0_epc;
  logic [7:0]  except_m;
  logic [5:0]  hw_int;
  logic [5:0]  ip_sync;
  logic        flush, cp0_we, badv_we, bd_out, redirect_valid;
  logic [31:0] excepttype, epc_out, badvaddr_out, redirect_pc;

  int   vectors    = 0;
  int   miscompares = 0;
  int   done_cnt   = 0;
  exp_t sb[$];

  exc_commit_ctrl #(
    .NUM_HW_INT  (6),
    .FLUSH_CYCLES(FlushCycles),
    .EXC_VECTOR  (ExcVec)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .valid_m       (valid_m),
    .stall_m       (stall_m),
    .pc_m          (pc_m),
    .in_ds_m       (in_ds_m),
    .except_m      (except_m),
    .adel_m        (adel_m),
    .ades_m        (ades_m),
    .bad_addr_m    (bad_addr_m),
    .hw_int        (hw_int),
    .cp0_status    (cp0_status),
    .cp0_cause     (cp0_cause),
    .cp0_epc       (cp0_epc),
    .redirect_ready(redirect_ready),
    .ip_sync       (ip_sync),
    .flush         (flush),
    .cp0_we        (cp0_we),
    .excepttype    (excepttype),
    .epc_out       (epc_out),
    .badvaddr_out  (badvaddr_out),
    .badv_we       (badv_we),
    .bd_out        (bd_out),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no completion expected completion", name);
  endtask

  // Reference: first set cause in priority order wins.
  function automatic exp_t model(input logic [5:0] ip, input logic [31:0] status,
                                 input logic [31:0] cause, input logic [31:0] pc,
                                 input logic ds, input logic [7:0] exc, input logic adel,
                                 input logic ades, input logic [31:0] badaddr,
                                 input logic [31:0] epc);
    exp_t e;
    bit   h[9];
    int   codes[9];
    bit   int_ok;
    codes  = '{1, 4, 4, 5, 8, 9, 14, 10, 12};
    int_ok = ((({ip, cause[9:8]} & status[15:8]) != 8'd0) && !status[1] && status[0]);
    h      = '{int_ok, exc[7], adel, ades, exc[6], exc[5], exc[4], exc[3], exc[2]};
    e      = '{default: '0};
    for (int i = 0; i < 9; i++) begin
      if (h[i] && !e.valid) begin
        e.valid   = 1'b1;
        e.code    = codes[i];
        e.badv_we = (i >= 1 && i <= 3);
        e.badv    = (i == 1) ? pc : badaddr;
        e.chk_epc = (i != 6);
        e.rpc     = (i == 6) ? epc : ExcVec;
      end
    end
    e.epc = ds ? pc - 32'd4 : pc;
    e.bd  = ds;
    return e;
  endfunction

  // Monitor: pops on each commit strobe and tracks the flush/redirect sequence.
  initial begin
    exp_t cur;
    bit   busy = 0;
    bit   post = 0;
    int   k    = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy = 0;
        post = 0;
      end else if (busy) begin
        k++;
        chk("cp0_we_single", cp0_we, 0);
        chk("flush_hold", flush, 1);
        chk("redirect_valid_timing", redirect_valid, k >= FlushCycles);
        chk("excepttype_hold", excepttype, cur.code);
        if (redirect_valid) chk("redirect_pc", redirect_pc, cur.rpc);
        if (redirect_valid && redirect_ready) begin
          busy = 0;
          post = 1;
          done_cnt++;
        end else if (k > 200) begin
          fail("monitor_handshake_timeout");
          busy = 0;
        end
      end else begin
        if (post) begin
          chk("post_flush_zero", {flush, redirect_valid, badv_we, bd_out}, 0);
          chk("post_excepttype_zero", excepttype, 0);
          chk("post_epc_zero", epc_out, 0);
          chk("post_redirect_pc_zero", redirect_pc, 0);
          post = 0;
        end
        if (cp0_we) begin
          if (sb.size() == 0) begin
            chk("unexpected_commit", excepttype, 0);
            vectors++;
            miscompares++;
            $display("FAIL unexpected_commit: got cp0_we=1 expected no commit");
          end else begin
            cur = sb.pop_front();
            chk("excepttype", excepttype, cur.code);
            if (cur.chk_epc) chk("epc_out", epc_out, cur.epc);
            chk("bd_out", bd_out, cur.bd);
            chk("badv_we", badv_we, cur.badv_we);
            if (cur.badv_we) chk("badvaddr_out", badvaddr_out, cur.badv);
            chk("commit_flush", flush, 1);
            chk("commit_no_redirect", redirect_valid, 0);
          end
          busy = 1;
          k    = 0;
        end else begin
          chk("idle_quiet", {flush, redirect_valid}, 0);
        end
      end
    end
  end

  task automatic set_instr(input logic [31:0] pc, input logic ds, input logic [7:0] exc,
                           input logic adel, input logic ades, input logic [31:0] badaddr);
    pc_m       = pc;
    in_ds_m    = ds;
    except_m   = exc;
    adel_m     = adel;
    ades_m     = ades;
    bad_addr_m = badaddr;
  endtask

  // Presents the driven instruction unstalled for one cycle and waits out its sequence.
  task automatic fire(input int ready_delay);
    exp_t e;
    int   start;
    int   rv_n;
    int   t;
    e = model(hw_int, cp0_status, cp0_cause, pc_m, in_ds_m, except_m, adel_m, ades_m,
              bad_addr_m, cp0_epc);
    if (e.valid) sb.push_back(e);
    start   = done_cnt;
    valid_m = 1'b1;
    stall_m = 1'b0;
    @(posedge clk);
    #1;
    valid_m = 1'b0;
    if (!e.valid) begin
      repeat (3) @(posedge clk);
      #1;
    end else begin
      rv_n = 0;
      t    = 0;
      while (done_cnt == start && t < 100) begin
        if (redirect_valid) rv_n++;
        redirect_ready = (rv_n > ready_delay);
        @(posedge clk);
        #1;
        t++;
      end
      redirect_ready = 1'b0;
      if (done_cnt == start) begin
        fail("txn_timeout");
        sb.delete();
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    valid_m = 1'b0; stall_m = 1'b0; redirect_ready = 1'b0;
    hw_int = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    set_instr(32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("reset_outputs", {flush, cp0_we, redirect_valid, badv_we, bd_out}, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_ip_sync", ip_sync, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Syscall, immediate handshake.
    set_instr(32'hBFC0_0100, 1'b0, 8'h40, 1'b0, 1'b0, 32'h0);
    fire(0);

    // AdES beats overflow, in a delay slot.
    set_instr(32'h8000_0010, 1'b1, 8'h04, 1'b0, 1'b1, 32'h8000_0003);
    fire(1);

    // Interrupt through the synchroniser beats a pending syscall.
    cp0_status = 32'h0000_0401;
    hw_int     = 6'h01;
    set_instr(32'h8000_0040, 1'b0, 8'h40, 1'b0, 1'b0, 32'h0);
    valid_m = 1'b1;
    stall_m = 1'b1;
    @(posedge clk);
    #1;
    chk("ip_sync_stage1", ip_sync, 0);
    chk("int_no_commit_1", cp0_we, 0);
    @(posedge clk);
    #1;
    chk("ip_sync_stage2", ip_sync[0], 1);
    chk("int_no_commit_2", cp0_we, 0);
    fire(0);

    // EXL masks the interrupt; syscall commits.
    cp0_status = 32'h0000_0403;
    set_instr(32'h8000_0080, 1'b0, 8'h40, 1'b0, 1'b0, 32'h0);
    fire(0);
    hw_int     = '0;
    cp0_status = '0;

    // eret with delayed ready.
    cp0_epc = 32'h8000_2000;
    set_instr(32'h8000_00C0, 1'b0, 8'h10, 1'b0, 1'b0, 32'h0);
    fire(3);

    // Reset during FLUSH abandons the sequence.
    set_instr(32'h8000_0100, 1'b0, 8'h40, 1'b0, 1'b0, 32'h0);
    sb.push_back(model(hw_int, cp0_status, cp0_cause, pc_m, in_ds_m, except_m, adel_m, ades_m,
                       bad_addr_m, cp0_epc));
    valid_m = 1'b1;
    @(posedge clk);
    #1;
    valid_m = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midreset_ctrl", {flush, cp0_we, redirect_valid, badv_we, bd_out}, 0);
    chk("midreset_excepttype", excepttype, 0);
    chk("midreset_epc", epc_out, 0);
    chk("midreset_redirect_pc", redirect_pc, 0);
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    set_instr(32'h8000_0200, 1'b0, 8'h08, 1'b0, 1'b0, 32'h0);
    fire(0);

    // Randomised transactions.
    for (int n = 0; n < 150; n++) begin
      int stalls;
      hw_int     = ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'h0;
      cp0_status = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0)};
      cp0_cause  = {22'h0, 2'($urandom), 8'h0};
      cp0_epc    = $urandom;
      set_instr($urandom, 1'($urandom), 8'($urandom & $urandom) & 8'hFC,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("ip_sync_follow", ip_sync, hw_int);
      stalls = $urandom_range(0, 2);
      if (stalls > 0) begin
        valid_m = 1'b1;
        stall_m = 1'b1;
        repeat (stalls) @(posedge clk);
        #1;
        chk("stall_no_commit", cp0_we, 0);
      end
      fire($urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
